// File: rtl/tribus_pkg.sv
// rtl/tribus_pkg.sv - shared state encoding and width helper for the tri-state bus arbiter
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // Ceiling log2 with a floor of one bit so every counter/index has a legal width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tribus_arb_rr_pick.sv
// rtl/tribus_arb_rr_pick.sv - combinational round-robin winner search starting after the last owner
module rr_pick
    import tribus_pkg::*;
#(
    parameter int N = 4,
    localparam int GW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic          valid,
    output logic [GW-1:0] win
);

    int            sum;
    logic [GW-1:0] idx;

    // Walk candidates from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        sum   = 0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            sum = int'(last) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = GW'(sum);
            if (req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/tribus_arb.sv
// rtl/tribus_arb.sv - round-robin tri-state bus arbiter with break-before-make turnaround (optional TRIBUS_TIMEOUT_EN hold limit)
module tribus_arb
    import tribus_pkg::*;
#(
    parameter int N         = 4,
    parameter int HOLD_MAX  = 8,
    parameter int TA_CYCLES = 1,
    localparam int GW = clog2(N)
) (
    input  logic          CK,
    input  logic          RN,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  EN,
    output logic [N-1:0]  GNT,
    output logic [GW-1:0] GID,
    output logic          BUSY
);

    localparam int TW = clog2(TA_CYCLES);

    state_t        state_q, state_d;
    logic [N-1:0]  en_q, en_d;
    logic [GW-1:0] gid_q, gid_d;
    logic [GW-1:0] last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          busy_q;
    logic          grant;
    logic          owner_drop;
    logic          hold_expired;

    logic          pick_valid;
    logic [GW-1:0] pick_win;
    logic [N-1:0]  pick_onehot;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (REQ),
        .last  (last_q),
        .valid (pick_valid),
        .win   (pick_win)
    );

    assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_win;
    assign owner_drop  = ~REQ[gid_q];

`ifdef TRIBUS_TIMEOUT_EN
    localparam int HW = clog2(HOLD_MAX);

    logic [HW-1:0] hcnt_q, hcnt_d;

    assign hold_expired = (hcnt_q == HW'(HOLD_MAX - 1));

    // Hold counter: restarts on every grant, saturates while the owner keeps the bus.
    always_comb begin
        hcnt_d = hcnt_q;
        if (grant) begin
            hcnt_d = '0;
        end else if (state_q == ST_OWN && !hold_expired) begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // Next-state logic: enables always pass through a zero turnaround before a new owner.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        gid_d   = gid_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant = 1'b1;
                end
            end
            ST_OWN: begin
                if (owner_drop || hold_expired) begin
                    state_d = ST_TURN;
                    en_d    = '0;
                    tcnt_d  = '0;
                end
            end
            ST_TURN: begin
                if (tcnt_q == TW'(TA_CYCLES - 1)) begin
                    if (pick_valid) begin
                        grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gid_d   = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
                gid_d   = '0;
            end
        endcase
        if (grant) begin
            state_d = ST_OWN;
            en_d    = pick_onehot;
            gid_d   = pick_win;
            last_d  = pick_win;
        end
    end

    // State, pointer and output registers; reset points last at N-1 so requester 0 wins first.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            gid_q   <= '0;
            last_q  <= GW'(N - 1);
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= |en_d;
        end
    end

    assign EN   = en_q;
    assign GNT  = en_q;
    assign GID  = gid_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_tribus_arb.sv
// tb/tb_tribus_arb.sv - scoreboard bench for tribus_arb with a behavioural ownership model
module tb_tribus_arb;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int TA   = 1;
`ifdef TRIBUS_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic         CK  = 1'b0;
    logic         RN  = 1'b0;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] EN;
    logic [N-1:0] GNT;
    logic [1:0]   GID;
    logic         BUSY;

    tribus_arb #(
        .N         (N),
        .HOLD_MAX  (HOLD),
        .TA_CYCLES (TA)
    ) dut (
        .CK   (CK),
        .RN   (RN),
        .REQ  (REQ),
        .EN   (EN),
        .GNT  (GNT),
        .GID  (GID),
        .BUSY (BUSY)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [N-1:0] en;
        logic [1:0]   gid;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, for how long, and how many dead cycles remain.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_held  = 0;
    int m_dead  = 0;
    int m_gid   = 0;

    task automatic model_pick();
        int c;
        for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (REQ[2'(c)]) begin
                m_owner = c;
                m_last  = c;
                m_held  = 0;
                m_gid   = c;
                return;
            end
        end
        m_gid = 0;
    endtask

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_owner = -1;
            m_last  = N - 1;
            m_held  = 0;
            m_dead  = 0;
            m_gid   = 0;
            exp_q.delete();
        end else begin
            if (m_owner >= 0) begin
                m_held++;
                if (!REQ[2'(m_owner)] || (TIMEOUT && m_held >= HOLD)) begin
                    m_owner = -1;
                    m_dead  = TA;
                end
            end else if (m_dead > 0) begin
                m_dead--;
                if (m_dead == 0) begin
                    model_pick();
                end
            end else begin
                model_pick();
            end
            exp_q.push_back('{en:   (m_owner >= 0) ? N'(1 << m_owner) : '0,
                              gid:  2'(m_gid),
                              busy: (m_owner >= 0)});
        end
    end

    logic [N-1:0] prev_en  = '0;
    bit           rst_seen = 1'b0;

    always @(negedge RN) rst_seen = 1'b1;

    // Monitor: pops the expected response for the last edge and checks bus-safety invariants.
    always @(negedge CK) begin
        exp_t e;
        if (rst_seen) begin
            prev_en  = '0;
            rst_seen = 1'b0;
        end
        if (!RN) begin
            chk("rst_en", EN, 0);
            chk("rst_gid", GID, 0);
            chk("rst_busy", BUSY, 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("en", EN, e.en);
            chk("gid", GID, e.gid);
            chk("busy", BUSY, e.busy);
        end
        chk("gnt_eq_en", GNT, EN);
        chk("onehot0", $onehot0(EN), 1);
        if (RN && prev_en != 0 && EN != 0) begin
            chk("no_handover", EN, prev_en);
        end
        prev_en = RN ? EN : '0;
    end

    task automatic drive(input logic [N-1:0] r, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CK);
            REQ = r;
        end
    endtask

    initial begin
        bit found;
        RN  = 1'b0;
        REQ = '0;
        repeat (3) @(negedge CK);
        #2 RN = 1'b1;

        // Asynchronous reset while requester 2 owns the bus.
        @(negedge CK);
        REQ   = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CK);
            if (EN == 4'b0100) found = 1'b1;
        end
        chk("s1_reach_owner2", EN, 4'b0100);
        REQ = 4'b1111;
        #2 RN = 1'b0;
        #1;
        chk("s1_async_en", EN, 0);
        chk("s1_async_gnt", GNT, 0);
        chk("s1_async_gid", GID, 0);
        chk("s1_async_busy", BUSY, 0);
        #1 RN = 1'b1;
        @(posedge CK);
        #1;
        chk("s1_first_grant", EN, 4'b0001);
        chk("s1_first_gid", GID, 0);

        // Single request from requester 1, then release.
        drive(4'b0000, 4);
        drive(4'b0010, 2);
        drive(4'b0000, 4);

        // All requesting: rotation under timeout, or a held owner without it.
        drive(4'b1111, 24);
        drive(4'b1110, 6);
        drive(4'b0000, 3);

        // Wrap and skip: last owner 2, then 0 wins over 2, then 2 again.
        drive(4'b0100, 3);
        drive(4'b0001, 1);
        drive(4'b0101, 1);
        drive(4'b0100, 4);
        drive(4'b0000, 3);

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 10000; i++) begin
            @(negedge CK);
            if ($urandom_range(0, 3) == 0) REQ = N'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 RN = 1'b0;
                #1 chk("rnd_async_en", EN, 0);
                #1 RN = 1'b1;
            end
        end

        REQ = '0;
        repeat (4) @(negedge CK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
